// File: rtl/king_pkg.sv
// Shared definitions for the branch-fetch unit: opcode, condition codes,
// flag bit positions, FSM state type and the branch target helper.
package king_pkg;

    localparam int ADDR_W = 16;
    localparam int INSTR_W = 16;

    // Opcode that marks a conditional branch in instr[15:12].
    localparam logic [3:0] OP_BR = 4'hF;

    // Condition codes carried in instr[11:8]; 8..15 are reserved and never taken.
    localparam logic [3:0] COND_ALWAYS = 4'h0;
    localparam logic [3:0] COND_Z      = 4'h1;
    localparam logic [3:0] COND_NZ     = 4'h2;
    localparam logic [3:0] COND_N      = 4'h3;
    localparam logic [3:0] COND_NN     = 4'h4;
    localparam logic [3:0] COND_C      = 4'h5;
    localparam logic [3:0] COND_NC     = 4'h6;
    localparam logic [3:0] COND_V      = 4'h7;

    // Bit positions inside the {Z,N,C,V} flags bus.
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_NEXT  = 2'd3
    } state_t;

    // Branch target: pc plus the sign-extended 8-bit offset, wrapping mod 2^16.
    function automatic logic [ADDR_W-1:0] branch_target(
        input logic [ADDR_W-1:0] pc,
        input logic [7:0]        offset
    );
        return pc + {{(ADDR_W-8){offset[7]}}, offset};
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of a branch condition code against the live flags.
module cond_eval
    import king_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       True
);

    // Decode the condition code; reserved codes resolve to not-taken.
    always_comb begin
        // NOTE: default first so every path assigns True and no latch is inferred.
        True = 1'b0;
        case (cond)
            COND_ALWAYS: True = 1'b1;
            COND_Z:      True = flags[FLAG_Z];
            COND_NZ:     True = ~flags[FLAG_Z];
            COND_N:      True = flags[FLAG_N];
            COND_NN:     True = ~flags[FLAG_N];
            COND_C:      True = flags[FLAG_C];
            COND_NC:     True = ~flags[FLAG_C];
            COND_V:      True = flags[FLAG_V];
            default:     True = 1'b0;
        endcase
    end

endmodule

// File: rtl/busca_desvio.sv
// Instruction fetch and branch detection unit: fetches one instruction per
// pass through FETCH, presents it in EXEC, and reports branch/condition/target.
module busca_desvio
    import king_pkg::*;
(
    input  logic                sys_clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   end_prox,
    output logic [ADDR_W-1:0]   end_atual,
    output logic                Desvio,
    output logic                True,
    output logic [ADDR_W-1:0]   end_desvio,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [INSTR_W-1:0]  mem_data,
    input  logic [3:0]          flags,
    input  logic                stall,
    output logic [INSTR_W-1:0]  instr,
    output logic                instr_valid,
    output logic [15:0]         instr_count
);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [15:0]        count_q, count_d;

    logic               in_exec;
    logic               is_branch;
    logic               cond_true;

    // State and datapath registers; reset forces everything back to IDLE at once.
    always_ff @(posedge sys_clock or posedge reset) begin
        // NOTE: reset is asynchronous so an abandoned FETCH drops mem_req without waiting for an edge.
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values together.
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: load pc, fetch until acknowledged, execute, advance.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        mem_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Any late mem_ack is ignored here; only end_prox matters.
                pc_d    = end_prox;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    instr_d = mem_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // A stall freezes the instruction in place; otherwise it retires.
                if (!stall) begin
                    count_d = count_q + 16'd1;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                pc_d    = end_prox;
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_exec   = (state_q == ST_EXEC);
    assign is_branch = (instr_q[15:12] == OP_BR);

    cond_eval u_cond_eval (
        .cond  (instr_q[11:8]),
        .flags (flags),
        .True  (cond_true)
    );

    // Decoder-facing outputs; branch indications are only meaningful in EXEC.
    assign end_atual   = pc_q;
    assign mem_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_count = count_q;
    assign instr_valid = in_exec;
    assign Desvio      = in_exec & is_branch;
    assign True        = in_exec & cond_true;
    assign end_desvio  = branch_target(pc_q, instr_q[7:0]);

endmodule

// File: tb/tb_busca_desvio.sv
// Directed self-checking bench for busca_desvio.
module tb_busca_desvio;

    logic        sys_clock;
    logic        reset;
    logic [15:0] end_prox;
    logic [15:0] end_atual;
    logic        Desvio;
    logic        True;
    logic [15:0] end_desvio;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic [3:0]  flags;
    logic        stall;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] instr_count;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_count = 16'd0;

    busca_desvio dut (
        .sys_clock   (sys_clock),
        .reset       (reset),
        .end_prox    (end_prox),
        .end_atual   (end_atual),
        .Desvio      (Desvio),
        .True        (True),
        .end_desvio  (end_desvio),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .flags       (flags),
        .stall       (stall),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_count (instr_count)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    task automatic tick();
        @(posedge sys_clock);
        #1;
    endtask

    // Wait (bounded) for the unit to raise mem_req.
    task automatic wait_req();
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL wait_req: mem_req=%b after %0d cycles, required 1", mem_req, n);
        end
    endtask

    // From FETCH: hold off the ack for 'waits' cycles, then deliver 'data'.
    task automatic do_fetch(input logic [15:0] data, input int waits);
        wait_req();
        mem_ack = 1'b0;
        for (int i = 0; i < waits; i++) tick();
        mem_ack  = 1'b1;
        mem_data = data;
        tick();
        mem_ack  = 1'b0;
    endtask

    // From EXEC: retire, load 'addr' in NEXT, then fetch 'data' there.
    task automatic advance(input logic [15:0] addr, input logic [15:0] data);
        stall    = 1'b0;
        end_prox = addr;
        tick();
        exp_count = exp_count + 16'd1;
        tick();
        do_fetch(data, 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++;
        if ({mem_req, Desvio, True, instr_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: {req,desvio,true,valid}=%b, required 0000",
                     {mem_req, Desvio, True, instr_valid});
        end
        checks++;
        if (end_atual !== 16'h0 || end_desvio !== 16'h0 || instr !== 16'h0 || instr_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: pc=%h tgt=%h instr=%h cnt=%h, required all 0000",
                     end_atual, end_desvio, instr, instr_count);
        end
    endtask

    task automatic test_basic_fetch();
        end_prox = 16'h0000;
        @(negedge sys_clock);
        reset = 1'b0;
        wait_req();
        checks++;
        if (mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL fetch_addr: mem_addr=%h, required 0000", mem_addr);
        end
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
                errors++;
                $display("FAIL fetch_hold: req=%b addr=%h, required 1/0000", mem_req, mem_addr);
            end
        end
        mem_ack  = 1'b1;
        mem_data = 16'h1234;
        tick();
        mem_ack  = 1'b0;
        checks++;
        if (instr !== 16'h1234 || instr_valid !== 1'b1 || Desvio !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL exec_basic: instr=%h valid=%b desvio=%b req=%b, required 1234/1/0/0",
                     instr, instr_valid, Desvio, mem_req);
        end
        end_prox = 16'h0001;
        stall    = 1'b0;
        tick();
        exp_count = exp_count + 16'd1;
        checks++;
        if (instr_count !== exp_count || instr_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL next_state: cnt=%h valid=%b req=%b, required %h/0/0",
                     instr_count, instr_valid, mem_req, exp_count);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0001) begin
            errors++;
            $display("FAIL next_fetch: req=%b addr=%h, required 1/0001", mem_req, mem_addr);
        end
        do_fetch(16'h0000, 0);
    endtask

    task automatic test_branch();
        advance(16'h0010, 16'hF1FE);
        flags = 4'b1000;
        #1;
        checks++;
        if (Desvio !== 1'b1 || True !== 1'b1 || end_desvio !== 16'h000E || end_atual !== 16'h0010) begin
            errors++;
            $display("FAIL br_taken: desvio=%b true=%b tgt=%h pc=%h, required 1/1/000E/0010",
                     Desvio, True, end_desvio, end_atual);
        end
        flags = 4'b0000;
        #1;
        checks++;
        if (True !== 1'b0 || Desvio !== 1'b1) begin
            errors++;
            $display("FAIL br_not_taken: true=%b desvio=%b, required 0/1", True, Desvio);
        end
        flags = 4'b0001;
        advance(16'h0020, 16'hF700);
        checks++;
        if (True !== 1'b1) begin
            errors++;
            $display("FAIL br_cond_v: true=%b, required 1", True);
        end
        flags = 4'b1110;
        #1;
        checks++;
        if (True !== 1'b0) begin
            errors++;
            $display("FAIL br_cond_v_clear: true=%b, required 0", True);
        end
    endtask

    task automatic test_wrap();
        advance(16'h0000, 16'hF0FF);
        checks++;
        if (end_desvio !== 16'hFFFF || True !== 1'b1) begin
            errors++;
            $display("FAIL wrap_low: tgt=%h true=%b, required FFFF/1", end_desvio, True);
        end
        advance(16'hFFFF, 16'hF001);
        checks++;
        if (end_desvio !== 16'h0000 || end_atual !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_high: tgt=%h pc=%h, required 0000/FFFF", end_desvio, end_atual);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr !== 16'hF001 || end_atual !== 16'hFFFF ||
                instr_count !== exp_count || mem_req !== 1'b0 || Desvio !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: valid=%b instr=%h pc=%h cnt=%h req=%b desvio=%b, required 1/F001/FFFF/%h/0/1",
                         instr_valid, instr, end_atual, instr_count, mem_req, Desvio, exp_count);
            end
        end
        stall = 1'b0;
        end_prox = 16'h0040;
        tick();
        exp_count = exp_count + 16'd1;
        checks++;
        if (instr_count !== exp_count || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: cnt=%h valid=%b, required %h/0", instr_count, instr_valid, exp_count);
        end
        tick();
        do_fetch(16'h0000, 0);
    endtask

    task automatic test_reserved_cond();
        flags = 4'hF;
        advance(16'h0050, 16'hF905);
        checks++;
        if (Desvio !== 1'b1 || True !== 1'b0 || end_desvio !== 16'h0055) begin
            errors++;
            $display("FAIL reserved_cond: desvio=%b true=%b tgt=%h, required 1/0/0055",
                     Desvio, True, end_desvio);
        end
    endtask

    task automatic test_reset_mid_fetch();
        stall    = 1'b0;
        end_prox = 16'h0070;
        tick();
        tick();
        wait_req();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || instr_count !== 16'h0 || end_atual !== 16'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_fetch: req=%b cnt=%h pc=%h valid=%b, required 0/0000/0000/0",
                     mem_req, instr_count, end_atual, instr_valid);
        end
        mem_ack  = 1'b1;
        mem_data = 16'hBEEF;
        end_prox = 16'h0090;
        @(negedge sys_clock);
        reset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || instr !== 16'h0) begin
            errors++;
            $display("FAIL idle_after_reset: req=%b instr=%h, required 0/0000", mem_req, instr);
        end
        tick();
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || instr !== 16'h0 || end_atual !== 16'h0090) begin
            errors++;
            $display("FAIL late_ack_ignored: req=%b instr=%h pc=%h, required 1/0000/0090",
                     mem_req, instr, end_atual);
        end
    endtask

    initial begin
        reset    = 1'b1;
        end_prox = 16'h0;
        mem_ack  = 1'b0;
        mem_data = 16'h0;
        flags    = 4'h0;
        stall    = 1'b0;
        test_reset();
        test_basic_fetch();
        test_branch();
        test_wrap();
        test_stall();
        test_reserved_cond();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
